// File: rtl/mshr_pkg.sv
// Shared constants, entry record and pointer sizing for the miss-status holding queue.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package mshr_pkg;

  localparam int MSHR_DEPTH  = 8;
  localparam int MSHR_ADDR_W = 27;
  localparam int MSHR_LAT_W  = 5;
  localparam int MSHR_WARP_W = 3;
  localparam int MSHR_SCB_W  = 2;

  // One queue slot at the default widths; mshr_entry keeps the same fields.
  typedef struct packed {
    logic                   valid;
    logic                   killed;
    logic [MSHR_SCB_W-1:0]  scb;
    logic [MSHR_WARP_W-1:0] warp;
    logic [MSHR_ADDR_W-1:0] addr;
    logic [MSHR_LAT_W-1:0]  cnt;
  } mshr_entry_t;

  // Pointer width. The extra MSB separates full from empty.
  function automatic int mshr_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mshr_entry.sv
// One miss slot: payload, saturating latency countdown, mature flag, warp-flush kill.
// Latency: loads on the write edge; mature the cycle after cnt reaches zero.
// Backpressure: none; the queue decides when to write and when to clear.
module mshr_entry
  import mshr_pkg::*;
#(
  parameter int ADDR_W = MSHR_ADDR_W,
  parameter int LAT_W  = MSHR_LAT_W,
  parameter int WARP_W = MSHR_WARP_W,
  parameter int SCB_W  = MSHR_SCB_W
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              wr_en,
  input  logic [SCB_W-1:0]  wr_scb,
  input  logic [WARP_W-1:0] wr_warp,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LAT_W-1:0]  wr_lat,
  input  logic              clr,
  input  logic              flush_valid,
  input  logic [WARP_W-1:0] flush_warp_id,
  output logic              valid,
  output logic              killed,
  output logic              mature,
  output logic [SCB_W-1:0]  scb,
  output logic [WARP_W-1:0] warp,
  output logic [ADDR_W-1:0] addr
);

  logic [LAT_W-1:0] cnt;
  logic             flush_hit;

  // Only occupied slots can be squashed; a slot being written this cycle is not.
  assign flush_hit = flush_valid & valid & (warp == flush_warp_id);
  assign mature    = (cnt == '0);

  // Payload and countdown: load on allocation, otherwise tick down while occupied.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      scb  <= '0;
      warp <= '0;
      addr <= '0;
      cnt  <= '0;
    end else if (wr_en) begin
      scb  <= wr_scb;
      warp <= wr_warp;
      addr <= wr_addr;
      cnt  <= wr_lat;
    end else if (valid && (cnt != '0)) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  // Occupancy flags: allocation overrides both retirement and flush.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      valid  <= 1'b0;
      killed <= 1'b0;
    end else if (wr_en) begin
      valid  <= 1'b1;
      killed <= 1'b0;
    end else if (clr) begin
      valid  <= 1'b0;
      killed <= 1'b0;
    end else if (flush_hit) begin
      killed <= 1'b1;
    end
  end

endmodule

// File: rtl/mshr_queue.sv
// In-order miss-status queue: parallel latency countdown, ordered feedback, warp flush.
// Latency: miss with latency L allocated at edge E can give fb_valid after edge E+L.
// Backpressure: head holds until fb_ready; allocation refused while full (no bypass).
module mshr_queue
  import mshr_pkg::*;
#(
  parameter int DEPTH  = MSHR_DEPTH,
  parameter int ADDR_W = MSHR_ADDR_W,
  parameter int LAT_W  = MSHR_LAT_W,
  parameter int WARP_W = MSHR_WARP_W,
  parameter int SCB_W  = MSHR_SCB_W
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic                          alloc_valid,
  input  logic                          alloc_hit_missbar,
  input  logic [SCB_W-1:0]              alloc_scb_id,
  input  logic [WARP_W-1:0]             alloc_warp_id,
  input  logic [ADDR_W-1:0]             alloc_addr,
  input  logic [LAT_W-1:0]              alloc_latency,
  output logic                          alloc_accept,
  output logic                          full,
  output logic [mshr_ptr_w(DEPTH)-1:0]  count,
  output logic                          fb_valid,
  input  logic                          fb_ready,
  output logic [SCB_W-1:0]              fb_scb_id,
  output logic [WARP_W-1:0]             fb_warp_id,
  output logic [ADDR_W-1:0]             fb_addr,
  input  logic                          flush_valid,
  input  logic [WARP_W-1:0]             flush_warp_id
);

  localparam int PTR_W = mshr_ptr_w(DEPTH);
  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              pop;

  logic [DEPTH-1:0]  e_valid;
  logic [DEPTH-1:0]  e_killed;
  logic [DEPTH-1:0]  e_mature;
  logic [DEPTH-1:0]  e_wr;
  logic [DEPTH-1:0]  e_clr;
  logic [SCB_W-1:0]  e_scb  [DEPTH];
  logic [WARP_W-1:0] e_warp [DEPTH];
  logic [ADDR_W-1:0] e_addr [DEPTH];

  assign wr_idx = wp[IDX_W-1:0];
  assign rd_idx = rp[IDX_W-1:0];

  // Occupancy derives from the pointer registers only, so it shows the state after the last edge.
  assign count = wp - rp;
  assign full  = (count == PTR_W'(DEPTH));

  assign alloc_accept = alloc_valid & ~alloc_hit_missbar & ~full;

  // Head view is a pure function of entry registers; no input reaches fb_*.
  assign fb_valid   = e_valid[rd_idx] & ~e_killed[rd_idx] & e_mature[rd_idx];
  assign fb_scb_id  = e_scb[rd_idx];
  assign fb_warp_id = e_warp[rd_idx];
  assign fb_addr    = e_addr[rd_idx];

  // Killed heads drain silently, one per cycle, regardless of maturity or fb_ready.
  assign pop = (fb_valid & fb_ready) | (e_valid[rd_idx] & e_killed[rd_idx]);

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign e_wr[i]  = alloc_accept & (wr_idx == IDX_W'(i));
    assign e_clr[i] = pop & (rd_idx == IDX_W'(i));

    mshr_entry #(
      .ADDR_W (ADDR_W),
      .LAT_W  (LAT_W),
      .WARP_W (WARP_W),
      .SCB_W  (SCB_W)
    ) u_entry (
      .clk           (clk),
      .resetb        (resetb),
      .wr_en         (e_wr[i]),
      .wr_scb        (alloc_scb_id),
      .wr_warp       (alloc_warp_id),
      .wr_addr       (alloc_addr),
      .wr_lat        (alloc_latency),
      .clr           (e_clr[i]),
      .flush_valid   (flush_valid),
      .flush_warp_id (flush_warp_id),
      .valid         (e_valid[i]),
      .killed        (e_killed[i]),
      .mature        (e_mature[i]),
      .scb           (e_scb[i]),
      .warp          (e_warp[i]),
      .addr          (e_addr[i])
    );
  end

  // Advance allocation and retirement pointers; both may move in the same cycle.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (alloc_accept) wp <= wp + PTR_W'(1);
      if (pop)          rp <= rp + PTR_W'(1);
    end
  end

endmodule

// File: doc/mshr_queue.md
# mshr_queue

Parametrised miss-status holding queue for the data-cache path. Every load miss (non-hit, valid address) is recorded with its scoreboard ID, warp ID, line address and miss latency. All entries count down in parallel, and matured entries retire in allocation order as negative-feedback events to the scoreboard over a ready/valid handshake. Adds full/occupancy reporting and per-warp flush, so the pipeline can stall on a full queue and squash misses of a killed warp.

## Interface
Parameters:
- DEPTH, 8: entry count; power of two, at least 2.
- ADDR_W, 27: line-address width.
- LAT_W, 5: latency counter width.
- WARP_W, 3: warp ID width.
- SCB_W, 2: scoreboard ID width.

Ports:
- clk  in  1  single clock, rising edge.
- resetb  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  address valid from the cache lookup stage.
- alloc_hit_missbar  in  1  1 = hit (ignored), 0 = miss.
- alloc_scb_id  in  SCB_W  scoreboard ID of the miss.
- alloc_warp_id  in  WARP_W  warp ID of the miss.
- alloc_addr  in  ADDR_W  line address.
- alloc_latency  in  LAT_W  miss latency in cycles.
- alloc_accept  out  1  combinational: alloc_valid & !alloc_hit_missbar & !full.
- full  out  1  registered: count == DEPTH.
- count  out  clog2(DEPTH)+1  registered occupancy, including killed entries.
- fb_valid  out  1  head entry is valid, not killed, and matured.
- fb_ready  in  1  scoreboard consumes feedback.
- fb_scb_id / fb_warp_id / fb_addr  out  SCB_W / WARP_W / ADDR_W  head payload.
- flush_valid  in  1  flush request.
- flush_warp_id  in  WARP_W  warp to squash.

## Operation
- Storage is a circular buffer: wp and rp are each clog2(DEPTH)+1 bits, and the MSB distinguishes full from empty. count = wp - rp.
- Each entry holds: valid, killed, scb, warp, addr, and cnt[LAT_W].
- Allocate when alloc_accept is 1:
  - entry[wp] gets the payload, cnt = alloc_latency, valid = 1, killed = 0.
  - wp increments.
- Countdown: every cycle, every valid entry with cnt != 0 decrements by 1. cnt saturates at 0. A newly written entry does not decrement in its write cycle.
- An entry is mature when cnt == 0.
- Retire the head (rp increments, valid clears) when either:
  - fb_valid & fb_ready, or
  - the head is valid and killed. This pop is silent, one per cycle, independent of maturity and fb_ready.
- Flush: on flush_valid, every valid entry with a matching warp gets killed = 1. A same-cycle allocation for that warp is NOT killed.
- A matured head entry holds fb_valid and payload stable until fb_ready. Younger matured entries wait behind it (in-order retirement).
- Same-cycle pop and allocate are both performed; count is unchanged.
- Allocation is refused while full is 1, even if the head pops in that cycle (no bypass).
- Hits and alloc_valid = 0 never allocate.

## Timing
- Reset values: wp = rp = 0, every entry valid = killed = 0, payload and cnt = 0.
- Outputs at reset: fb_valid = 0, full = 0, count = 0, fb_* = 0.
- Reset may assert mid-operation. It discards all entries immediately; no feedback is emitted for them.
- Miss latency: allocate at edge E with latency L. fb_valid can first be 1 in the cycle following edge E+L. L = 0 gives fb_valid in the cycle right after E.
- fb_valid and fb_* are combinational from head registers only. There is no input-to-output path.
- full and count reflect the state after the previous edge.
- Pointer wrap-around is transparent: index = pointer[clog2(DEPTH)-1:0].

## Structure
- Package mshr_pkg holds:
  - default widths and depth constants;
  - the entry record (valid, killed, scb, warp, addr, cnt);
  - the function for pointer width (clog2(DEPTH)+1).
- Sub-module mshr_entry holds one entry's registers, saturating down-counter, mature flag, and flush-match/kill logic.
- mshr_queue instantiates DEPTH copies of mshr_entry and owns the pointers, head mux, and handshake.

## Test plan
- Single miss, L = 3, fb_ready = 1:
  - fb_valid is 1 for exactly one cycle, starting 4 cycles after the allocation cycle;
  - payload matches the allocation;
  - count returns to 0.
- Fill with 8 misses (L = 5) and hold fb_ready = 0:
  - full = 1 and count = 8;
  - a 9th miss gets alloc_accept = 0;
  - raising fb_ready drains 8 events in order on consecutive cycles.
- Two misses, first L = 10 and second L = 1:
  - the second matures first but is not emitted until after the first;
  - both entries are emitted in allocation order.
- Four entries (warps 1, 2, 1, 3), then flush warp 1 in the same cycle as a new warp-1 allocation:
  - only warp 2, warp 3 and the new warp-1 entry produce feedback;
  - the killed entries pop silently.
- Assert resetb low while 5 entries are pending and fb_valid = 1:
  - next cycle fb_valid = 0 and count = 0;
  - no further events after release.
- Full queue with the head popping and a simultaneous miss:
  - the miss is refused;
  - count goes 8 → 7;
  - the next cycle the miss is accepted.
